ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU, branch/jump resolution and the EX/MEM pipeline register.
// Redirect outputs are combinational; every *M output comes straight from a flop.
module ex_mem_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              MemReadE,
    input  logic              MemWriteE,
    input  logic              ALUSrcE,
    input  logic              JumpE,
    input  logic              RegWriteE,
    input  logic              BranchE,
    input  logic              MuxjalrE,
    input  logic [3:0]        ALUOpE,
    input  logic [2:0]        WriteBackE,
    input  logic [2:0]        funct3E,
    input  logic [4:0]        RdE,
    input  logic [4:0]        Rs1E,
    input  logic [4:0]        Rs2E,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] PCE,
    input  logic [DATA_W-1:0] ImmExtE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic              RegWriteW,
    input  logic [4:0]        RdW,
    input  logic [DATA_W-1:0] ResultW,
    output logic              MemReadM,
    output logic              MemWriteM,
    output logic              RegWriteM,
    output logic [2:0]        WriteBackM,
    output logic [2:0]        funct3M,
    output logic [4:0]        RdM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] PCPlus4M,
    output logic [DATA_W-1:0] ImmExtM,
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] jalr_sum;
    logic              branch_taken;

    function automatic logic [DATA_W-1:0] alu_f(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [SH_W-1:0]          sh;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return {{(DATA_W-1){1'b0}}, (sa < sb)};
            4'd4:    return {{(DATA_W-1){1'b0}}, (a < b)};
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return DATA_W'(sa >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return '0;
        endcase
    endfunction

    function automatic logic branch_f(
        input logic [2:0]        f3,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Forwarding reads the registered MEM values (also while stalled); MEM beats WB, x0 never forwards.
    always_comb begin
        fwd_a = RD1E;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            fwd_a = ALUResultM;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            fwd_a = ResultW;
        end
    end

    always_comb begin
        fwd_b = RD2E;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            fwd_b = ALUResultM;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            fwd_b = ResultW;
        end
    end

    assign src_b        = ALUSrcE ? ImmExtE : fwd_b;
    assign alu_result   = alu_f(ALUOpE, fwd_a, src_b);
    assign branch_taken = branch_f(funct3E, fwd_a, fwd_b);
    assign jalr_sum     = fwd_a + ImmExtE;

    assign PCSrcE    = JumpE | (BranchE & branch_taken);
    assign PCTargetE = MuxjalrE ? {jalr_sum[DATA_W-1:1], 1'b0} : (PCE + ImmExtE);

    // EX -> MEM boundary
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            MemReadM   <= 1'b0;
            MemWriteM  <= 1'b0;
            RegWriteM  <= 1'b0;
            WriteBackM <= '0;
            funct3M    <= '0;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            ImmExtM    <= '0;
        end else if (!stall) begin
            MemReadM   <= MemReadE;
            MemWriteM  <= MemWriteE;
            RegWriteM  <= RegWriteE;
            WriteBackM <= WriteBackE;
            funct3M    <= funct3E;
            RdM        <= RdE;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
            ImmExtM    <= ImmExtE;
        end
    end

endmodule
